// File: rtl/colparity_if.sv
// Slice-memory and control bundle between a column-parity engine and its host.
// The host drives start/mode and the combinational read data; the engine drives the rest.
interface colparity_if #(
  parameter int unsigned COLS  = 5,
  parameter int unsigned ROWS  = 5,
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned W      = ROWS * COLS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, rd_data,
    input  rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, mode, rd_data,
    output rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/colparity_engine.sv
// Column-parity (theta-style) engine: PASS1 gathers per-slice column parities,
// PASS2 (theta mode) rewrites each slice mixed with neighbouring-column parities.
module colparity_engine #(
  parameter int unsigned COLS  = 5,
  parameter int unsigned ROWS  = 5,
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  colparity_if.slave  bus
);
  localparam int unsigned W      = ROWS * COLS;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] z;
  logic [ADDR_W-1:0] z_nx;
  logic              mode_q;
  logic              mode_nx;
  logic [COLS-1:0]   par [DEPTH];
  logic              par_we;

  logic              wr_en_q,   wr_en_nx;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nx;
  logic [W-1:0]      wr_data_q, wr_data_nx;
  logic              busy_q,    busy_nx;
  logic              done_q,    done_nx;

  logic              last_c;
  logic [ROWS-1:0]   col_c [COLS];
  logic [COLS-1:0]   par_c;
  logic [COLS-1:0]   cur_c;
  logic [COLS-1:0]   prv_c;
  logic [COLS-1:0]   mix_c;
  logic [W-1:0]      theta_c;

  assign last_c = (z == ADDR_W'(DEPTH - 1));
  assign cur_c  = par[z];
  assign prv_c  = par[z - ADDR_W'(1)];

  // Column parity of the current slice and the theta mix; wrap in x and z is modular.
  for (genvar gx = 0; gx < COLS; gx++) begin : g_col
    for (genvar gy = 0; gy < ROWS; gy++) begin : g_row
      assign col_c[gx][gy]          = bus.rd_data[gy*COLS + gx];
      assign theta_c[gy*COLS + gx]  = bus.rd_data[gy*COLS + gx] ^ mix_c[gx];
    end
    assign par_c[gx] = ^col_c[gx];
    assign mix_c[gx] = cur_c[(gx + COLS - 1) % COLS] ^ prv_c[(gx + 1) % COLS];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nx = S_PASS1;
      S_PASS1: if (last_c)    state_nx = mode_q ? S_DONE : S_PASS2;
      S_PASS2: if (last_c)    state_nx = S_DONE;
      S_DONE:                 state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Output / datapath next values, registered below
  always_comb begin
    z_nx       = '0;
    mode_nx    = mode_q;
    par_we     = 1'b0;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr_q;
    wr_data_nx = wr_data_q;
    busy_nx    = (state_nx == S_PASS1) || (state_nx == S_PASS2);
    done_nx    = (state_nx == S_DONE);
    unique case (state)
      S_IDLE: begin
        if (bus.start) mode_nx = bus.mode;
      end
      S_PASS1: begin
        z_nx   = last_c ? '0 : z + ADDR_W'(1);
        par_we = 1'b1;
        if (mode_q) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = z;
          wr_data_nx = W'(par_c);
        end
      end
      S_PASS2: begin
        z_nx       = last_c ? '0 : z + ADDR_W'(1);
        wr_en_nx   = 1'b1;
        wr_addr_nx = z;
        wr_data_nx = theta_c;
      end
      default: ;
    endcase
  end

  // Registered datapath, outputs and parity array
  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= '0;
      mode_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) par[i] <= '0;
    end else begin
      z         <= z_nx;
      mode_q    <= mode_nx;
      wr_en_q   <= wr_en_nx;
      wr_addr_q <= wr_addr_nx;
      wr_data_q <= wr_data_nx;
      busy_q    <= busy_nx;
      done_q    <= done_nx;
      if (par_we) par[z] <= par_c;
    end
  end

  assign bus.rd_addr = z;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
